// File: rtl/udp_tx_payload_serializer.sv
// Pops words from the tx data FIFO and streams them MSB-first as bytes to the UDP/IP framer.
// Optional macro UDP_TX_SER_PREFETCH_EN adds a second word register so consecutive words stream without a bubble.
module udp_tx_payload_serializer #(
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int UNDERRUN_WIDTH = 16
) (
  input  logic                      rd_clk,
  input  logic                      rd_rst,
  input  logic [DATA_WIDTH-1:0]     i_fifo_rd_data,
  input  logic                      i_fifo_rd_vld,
  output logic                      o_fifo_rd_en,
  input  logic                      i_tx_start,
  input  logic [LEN_WIDTH-1:0]      i_pkt_len,
  output logic [7:0]                o_tx_byte,
  output logic                      o_tx_byte_vld,
  input  logic                      i_tx_byte_rdy,
  output logic                      o_tx_last,
  output logic                      o_tx_busy,
  output logic                      o_tx_done,
  output logic [UNDERRUN_WIDTH-1:0] o_underrun_cnt
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                    r_state;
  logic [LEN_WIDTH-1:0]      r_remaining;
  logic [IDX_W-1:0]          r_idx;
  logic [DATA_WIDTH-1:0]     r_wordReg;
  logic [UNDERRUN_WIDTH-1:0] r_underrun;

  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_lastByte;
  logic                  w_wordEnd;

  assign w_shifted  = r_wordReg << {r_idx, 3'b000};
  assign w_accept   = (r_state == SHIFT) & i_tx_byte_rdy;
  assign w_lastByte = (r_remaining == LEN_WIDTH'(1));
  assign w_wordEnd  = (r_idx == LAST_IDX);

`ifdef UDP_TX_SER_PREFETCH_EN
  logic [DATA_WIDTH-1:0] r_nextReg;
  logic                  r_nextVld;
  logic [LEN_WIDTH-1:0]  r_unpopped;

  // r_unpopped counts packet bytes not yet covered by any popped word, so pops stop at ceil(len/BYTES)
  assign w_pop = i_fifo_rd_vld & ~r_nextVld & (r_unpopped != '0) &
                 ((r_state == LOAD) | (r_state == SHIFT));
`else
  assign w_pop = i_fifo_rd_vld & (r_state == LOAD);
`endif

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_idx       <= '0;
      r_wordReg   <= '0;
      r_underrun  <= '0;
`ifdef UDP_TX_SER_PREFETCH_EN
      r_nextReg   <= '0;
      r_nextVld   <= 1'b0;
      r_unpopped  <= '0;
`endif
    end else begin
`ifdef UDP_TX_SER_PREFETCH_EN
      if (w_pop) begin
        r_unpopped <= (r_unpopped > LEN_WIDTH'(BYTES)) ? (r_unpopped - LEN_WIDTH'(BYTES)) : '0;
      end
`endif
      case (r_state)
        IDLE: begin
          if (i_tx_start && (i_pkt_len != '0)) begin
            r_remaining <= i_pkt_len;
`ifdef UDP_TX_SER_PREFETCH_EN
            r_unpopped  <= i_pkt_len;
`endif
            r_state     <= LOAD;
          end
        end
        LOAD: begin
          if (w_pop) begin
            r_wordReg <= i_fifo_rd_data;
            r_idx     <= '0;
            r_state   <= SHIFT;
          end else if (r_underrun != '1) begin
            r_underrun <= r_underrun + 1'b1;
          end
        end
        SHIFT: begin
`ifdef UDP_TX_SER_PREFETCH_EN
          // A pop that lands exactly on an accepted word boundary goes straight into r_wordReg below
          if (w_pop && !(w_accept && w_wordEnd && !w_lastByte)) begin
            r_nextReg <= i_fifo_rd_data;
            r_nextVld <= 1'b1;
          end
`endif
          if (w_accept) begin
            r_remaining <= r_remaining - 1'b1;
            r_idx       <= r_idx + 1'b1;
            if (w_lastByte) begin
              r_state <= DONE;
            end else if (w_wordEnd) begin
`ifdef UDP_TX_SER_PREFETCH_EN
              r_idx <= '0;
              if (r_nextVld) begin
                r_wordReg <= r_nextReg;
                r_nextVld <= 1'b0;
              end else if (w_pop) begin
                r_wordReg <= i_fifo_rd_data;
              end else begin
                r_state <= LOAD;
              end
`else
              r_state <= LOAD;
`endif
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_fifo_rd_en   = w_pop;
  assign o_tx_byte      = w_shifted[DATA_WIDTH-1 -: 8];
  assign o_tx_byte_vld  = (r_state == SHIFT);
  assign o_tx_last      = (r_state == SHIFT) & w_lastByte;
  assign o_tx_busy      = (r_state != IDLE);
  assign o_tx_done      = (r_state == DONE);
  assign o_underrun_cnt = r_underrun;

endmodule
